// File: rtl/box_drawer_pkg.sv
// box_drawer shared types and constants.
// State encoding, screen limits and palette.
package box_drawer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ERASE,
    DRAW,
    DONE
  } state_t;

  localparam logic [7:0] SCREEN_W = 8'd160;
  localparam logic [7:0] SCREEN_H = 8'd120;

  localparam logic [2:0] BG_COLOUR   = 3'b000;
  localparam logic [2:0] FALL_COLOUR = 3'b110;
  localparam logic [2:0] FLY_COLOUR  = 3'b111;

  localparam logic [6:0] BOX_RESET_Y = 7'd60;

  function automatic logic [2:0] box_colour(
    input logic fly
  );
    return fly ? FLY_COLOUR : FALL_COLOUR;
  endfunction

endpackage

// File: rtl/box_drawer_if.sv
// box_drawer bus: box register side in,
// VGA adapter side out.
interface box_drawer_if;

  logic       frame_tick;
  logic [6:0] y_coordinate;
  logic       flying;
  logic       busy;
  logic       done;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot;

  modport master (
    output frame_tick,
    output y_coordinate,
    output flying,
    input  busy,
    input  done,
    input  x_out,
    input  y_out,
    input  colour,
    input  plot
  );

  modport slave (
    input  frame_tick,
    input  y_coordinate,
    input  flying,
    output busy,
    output done,
    output x_out,
    output y_out,
    output colour,
    output plot
  );

endinterface

// File: rtl/box_drawer_square_scan_counter.sv
// Raster index over an S x S square, S = 2**LOG2.
// Low bits give column, high bits give row.
module box_drawer_square_scan_counter #(
  parameter int LOG2 = 2
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            clear,
  input  logic            enable,
  output logic [LOG2-1:0] col_off,
  output logic [LOG2-1:0] row_off,
  output logic            last
);

  logic [2*LOG2-1:0] idx;

  // clear wins over enable; wraps after the last pixel
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (enable) begin
      idx <= idx + 1'b1;
    end
  end

  assign col_off = idx[LOG2-1:0];
  assign row_off = idx[2*LOG2-1:LOG2];
  assign last    = &idx;

endmodule

// File: rtl/box_drawer.sv
// box_drawer: per-frame erase then redraw of the box.
// Optional: BOX_DRAWER_SKIP_UNCHANGED_EN skips unchanged frames.
module box_drawer
  import box_drawer_pkg::*;
#(
  parameter int BOX_X    = 20,
  parameter int BOX_LOG2 = 2
) (
  input logic        clock,
  input logic        resetn,
  box_drawer_if.slave bus
);

  localparam logic [7:0] X0 = 8'(BOX_X);

  state_t               state;
  logic [6:0]           old_y;
  logic [6:0]           new_y;
  logic [2:0]           new_col;
  logic [BOX_LOG2-1:0]  col_off;
  logic [BOX_LOG2-1:0]  row_off;
  logic                 last;
  logic                 scan_clr;
  logic                 scan_en;
  logic [6:0]           base;
  logic [7:0]           row_sum;
  logic                 skip;

  assign scan_clr = (state == IDLE)
                  | ((state == ERASE) & last);
  assign scan_en  = (state == ERASE)
                  | (state == DRAW);
  assign base     = (state == DRAW) ? new_y : old_y;
  assign row_sum  = {1'b0, base} + 8'(row_off);

  box_drawer_square_scan_counter #(
    .LOG2(BOX_LOG2)
  ) u_scan (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (scan_clr),
    .enable  (scan_en),
    .col_off (col_off),
    .row_off (row_off),
    .last    (last)
  );

`ifdef BOX_DRAWER_SKIP_UNCHANGED_EN
  logic [2:0] last_col;

  assign skip = (bus.y_coordinate == old_y)
              & (box_colour(bus.flying) == last_col);

  // colour of the box currently on screen
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_col <= FALL_COLOUR;
    end else if (state == DONE) begin
      last_col <= new_col;
    end
  end
`else
  assign skip = 1'b0;
`endif

  // frame sequencer with registered pixel outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      old_y      <= BOX_RESET_Y;
      new_y      <= BOX_RESET_Y;
      new_col    <= FALL_COLOUR;
      bus.plot   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.x_out  <= '0;
      bus.y_out  <= '0;
      bus.colour <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.plot <= 1'b0;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          if (bus.frame_tick) begin
            new_y   <= bus.y_coordinate;
            new_col <= box_colour(bus.flying);
            state   <= skip ? DONE : ERASE;
          end
        end
        ERASE, DRAW: begin
          bus.busy   <= 1'b1;
          bus.done   <= 1'b0;
          bus.x_out  <= X0 + 8'(col_off);
          bus.y_out  <= row_sum[6:0];
          bus.plot   <= row_sum < SCREEN_H;
          bus.colour <= (state == DRAW)
                      ? new_col : BG_COLOUR;
          if (last) begin
            state <= (state == ERASE)
                   ? DRAW : DONE;
          end
        end
        DONE: begin
          bus.plot <= 1'b0;
          bus.busy <= 1'b1;
          bus.done <= 1'b1;
          old_y    <= new_y;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_box_drawer.sv
// box_drawer bench: directed and random frames
// checked against a pixel-list reference model.
module tb_box_drawer;

  localparam int BX   = 20;
  localparam int S    = 4;
  localparam int SH   = 120;
  localparam int C_BG = 0;
  localparam int C_FA = 6;
  localparam int C_FL = 7;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   total  = 0;
  int   bad    = 0;
  int   m_old_y;
  int   m_last_col;

  box_drawer_if bus();

  box_drawer #(
    .BOX_X    (BX),
    .BOX_LOG2 (2)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(
    input int cyc, input int x,
    input int y, input int c
  );
    return {6'd0, cyc[7:0], x[7:0],
            y[6:0], c[2:0]};
  endfunction

  task automatic run_frame(
    input int y, input int fly,
    input int t1, input int t2,
    input int rst_at
  );
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    int  done_n = 0;
    int  done_c = -1;
    int  busy_n = 0;
    int  busy_f = -1;
    int  busy_l = -1;
    int  col;
    int  n_exp;
    bit  skip;
    int  tk1, tk2;

    col  = fly ? C_FL : C_FA;
    skip = 1'b0;
`ifdef BOX_DRAWER_SKIP_UNCHANGED_EN
    skip = (y == m_old_y) && (col == m_last_col);
`endif
    tk1 = skip ? 0 : t1;
    tk2 = skip ? 0 : t2;

    bus.y_coordinate = 7'(y);
    bus.flying       = fly[0];
    bus.frame_tick   = 1'b1;
    @(posedge clock); #1;
    bus.frame_tick   = 1'b0;
    bus.y_coordinate = 7'($urandom);
    bus.flying       = 1'($urandom);

    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == rst_at) begin
        #3 resetn = 1'b0;
        #1;
        check("rst_plot", 32'(bus.plot), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        @(posedge clock);
        @(posedge clock);
        #1 resetn = 1'b1;
        m_old_y    = 60;
        m_last_col = C_FA;
        return;
      end
      bus.frame_tick = (cyc == tk1) || (cyc == tk2);
      @(posedge clock); #1;
      if (bus.plot === 1'b1)
        obs_q.push_back(pack(cyc,
          int'(bus.x_out), int'(bus.y_out),
          int'(bus.colour)));
      if (bus.done === 1'b1) begin
        done_n++;
        done_c = cyc;
      end
      if (bus.busy === 1'b1) begin
        busy_n++;
        if (busy_f < 0) busy_f = cyc;
        busy_l = cyc;
      end
    end
    bus.frame_tick = 1'b0;

    if (!skip) begin
      for (int ph = 0; ph < 2; ph++)
        for (int r = 0; r < S; r++)
          for (int c = 0; c < S; c++) begin
            int row;
            row = (ph == 1 ? y : m_old_y) + r;
            if (row < SH)
              exp_q.push_back(pack(
                1 + ph * S * S + r * S + c,
                BX + c, row,
                ph == 1 ? col : C_BG));
          end
    end
    n_exp = skip ? 1 : 2 * S * S + 1;

    check("plot_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size())
        check($sformatf("pixel%0d", i),
              obs_q[i], exp_q[i]);
    check("done_pulses", done_n, 1);
    check("done_cycle", done_c, n_exp);
    check("busy_cycles", busy_n, n_exp);
    check("busy_first", busy_f, 1);
    check("busy_last", busy_l, n_exp);
    check("idle_busy", 32'(bus.busy), 0);

    m_old_y    = y;
    m_last_col = col;
  endtask

  initial begin
    bus.frame_tick   = 1'b0;
    bus.y_coordinate = '0;
    bus.flying       = 1'b0;
    m_old_y          = 60;
    m_last_col       = C_FA;

    repeat (2) @(posedge clock);
    #1;
    check("reset_plot", 32'(bus.plot), 0);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    check("reset_x", 32'(bus.x_out), 0);
    check("reset_y", 32'(bus.y_out), 0);
    check("reset_col", 32'(bus.colour), 0);
    resetn = 1'b1;
    @(posedge clock); #1;
    check("idle_plot", 32'(bus.plot), 0);

    run_frame(60, 0, 0, 0, 0);
    run_frame(70, 1, 0, 0, 0);
    run_frame(118, 0, 0, 0, 0);
    run_frame(30, 1, 5, 33, 0);
    run_frame(50, 0, 0, 0, 10);
    run_frame(90, 1, 0, 0, 0);
    run_frame(60, 0, 0, 0, 0);
    run_frame(60, 0, 0, 0, 0);

    for (int k = 0; k < 12; k++) begin
      int ry, rf, ra, rb;
      ry = $urandom_range(0, 127);
      rf = $urandom_range(0, 1);
      ra = $urandom_range(0, 33);
      rb = $urandom_range(0, 33);
      if (ra == 1) ra = 0;
      if (rb == 1) rb = 0;
      run_frame(ry, rf, ra, rb, 0);
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
